// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory request/ack handshake between fetch and imem
interface fetch_stage_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC owner, imem fetch handshake, IF/ID register, skid buffer, delay-slot redirects
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_WORD = 32'h8B1F03FF
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master imem,
  input  logic          stall,
  input  logic          br_taken,
  input  logic [1:0]    br_sel,
  input  logic [25:0]   BrAddr26,
  input  logic [18:0]   CondAddr19,
  input  logic [63:0]   br_reg_val,
  output logic [31:0]   instruction,
  output logic [63:0]   if_pc,
  output logic          if_valid
);

  typedef enum logic {FETCH, BUFFERED} state_t;

  state_t      state, state_n;
  logic        req_q, req_n;
  logic [63:0] fetch_pc, fetch_pc_n;
  logic [31:0] instr_n;
  logic [63:0] if_pc_n;
  logic        if_valid_n;
  logic [31:0] skid_word, skid_word_n;
  logic [63:0] skid_pc, skid_pc_n;
  logic        pend_valid, pend_valid_n;
  logic [63:0] pend_target, pend_target_n;

  logic        fetch_done;
  logic        br_acc;
  logic [63:0] off26, off19, br_target, next_addr;

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = fetch_pc & ~64'h3;

  // req_q gates the ack so nothing completes before the first request is issued
  assign fetch_done = req_q & imem.imem_ack;
  assign br_acc     = br_taken & if_valid & ~stall;

  assign off26 = {{36{BrAddr26[25]}}, BrAddr26, 2'b00};
  assign off19 = {{43{CondAddr19[18]}}, CondAddr19, 2'b00};

  always_comb begin
    br_target = br_reg_val & ~64'h3;
    case (br_sel)
      2'b00:   br_target = if_pc + off26;
      2'b01:   br_target = if_pc + off19;
      default: br_target = br_reg_val & ~64'h3;
    endcase
  end

  // A redirect accepted this cycle outranks a parked one, which outranks sequential flow
  assign next_addr = br_acc     ? br_target   :
                     pend_valid ? pend_target : fetch_pc + 64'd4;

  always_comb begin
    state_n       = state;
    fetch_pc_n    = fetch_pc;
    instr_n       = instruction;
    if_pc_n       = if_pc;
    if_valid_n    = if_valid;
    skid_word_n   = skid_word;
    skid_pc_n     = skid_pc;
    pend_valid_n  = pend_valid;
    pend_target_n = pend_target;

    case (state)
      FETCH: begin
        if (fetch_done) begin
          fetch_pc_n   = next_addr;
          pend_valid_n = 1'b0;
          if (stall) begin
            skid_word_n = imem.imem_rdata;
            skid_pc_n   = fetch_pc;
            state_n     = BUFFERED;
          end else begin
            instr_n    = imem.imem_rdata;
            if_pc_n    = fetch_pc;
            if_valid_n = 1'b1;
          end
        end else if (!stall) begin
          instr_n    = NOP_WORD;
          if_valid_n = 1'b0;
          if (br_acc) begin
            pend_valid_n  = 1'b1;
            pend_target_n = br_target;
          end
        end
      end
      BUFFERED: begin
        if (!stall) begin
          instr_n    = skid_word;
          if_pc_n    = skid_pc;
          if_valid_n = 1'b1;
          state_n    = FETCH;
          // Skid word is the delay slot and nothing is in flight, so retarget directly
          if (br_acc) fetch_pc_n = br_target;
        end
      end
      default: state_n = FETCH;
    endcase

    req_n = (state_n == FETCH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FETCH;
      req_q       <= 1'b0;
      fetch_pc    <= RESET_PC;
      instruction <= NOP_WORD;
      if_pc       <= 64'h0;
      if_valid    <= 1'b0;
      skid_word   <= NOP_WORD;
      skid_pc     <= 64'h0;
      pend_valid  <= 1'b0;
      pend_target <= 64'h0;
    end else begin
      state       <= state_n;
      req_q       <= req_n;
      fetch_pc    <= fetch_pc_n;
      instruction <= instr_n;
      if_pc       <= if_pc_n;
      if_valid    <= if_valid_n;
      skid_word   <= skid_word_n;
      skid_pc     <= skid_pc_n;
      pend_valid  <= pend_valid_n;
      pend_target <= pend_target_n;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;
  localparam logic [63:0] RPC = 64'h100;
  localparam logic [31:0] NOP = 32'h8B1F03FF;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, br_taken;
  logic [1:0]  br_sel;
  logic [25:0] BrAddr26;
  logic [18:0] CondAddr19;
  logic [63:0] br_reg_val;
  logic [31:0] instruction;
  logic [63:0] if_pc;
  logic        if_valid;

  int checks = 0;
  int errors = 0;
  logic [63:0] ea, lp;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(RPC), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .imem(bus.master), .stall(stall), .br_taken(br_taken),
    .br_sel(br_sel), .BrAddr26(BrAddr26), .CondAddr19(CondAddr19), .br_reg_val(br_reg_val),
    .instruction(instruction), .if_pc(if_pc), .if_valid(if_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[33:2] ^ {2'b00, a[63:34]} ^ 32'h3C3CA5A5;
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    stall = 0; br_taken = 0; br_sel = 0; BrAddr26 = 0; CondAddr19 = 0; br_reg_val = 0;
    bus.imem_ack = 0;
  endtask

  task automatic test_reset;
    clear_inputs();
    reset = 0;
    tick(); tick();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", if_valid); end
    checks++; if (instruction !== NOP) begin errors++; $display("FAIL reset_instr got %h want %h", instruction, NOP); end
    checks++; if (if_pc !== 64'h0) begin errors++; $display("FAIL reset_pc got %h want 0", if_pc); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== RPC) begin errors++; $display("FAIL reset_addr got %h want %h", bus.imem_addr, RPC); end
    reset = 1;
    tick();
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b want 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== RPC) begin errors++; $display("FAIL first_addr got %h want %h", bus.imem_addr, RPC); end
  endtask

  task automatic test_sequential;
    bus.imem_ack = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== RPC + 64'(4*k)) begin errors++; $display("FAIL seq_pc got %h/%b want %h/1", if_pc, if_valid, RPC + 64'(4*k)); end
      checks++; if (instruction !== mem_word(RPC + 64'(4*k))) begin errors++; $display("FAIL seq_instr got %h want %h", instruction, mem_word(RPC + 64'(4*k))); end
      checks++; if (bus.imem_addr !== RPC + 64'(4*(k+1))) begin errors++; $display("FAIL seq_addr got %h want %h", bus.imem_addr, RPC + 64'(4*(k+1))); end
    end
    lp = RPC + 64'd12;
    ea = RPC + 64'd16;
  endtask

  task automatic test_wait_states;
    for (int k = 0; k < 6; k++) begin
      bus.imem_ack = (k % 3 == 2);
      tick();
      if (k % 3 == 2) begin
        checks++; if (if_valid !== 1'b1 || if_pc !== ea) begin errors++; $display("FAIL wait_pc got %h/%b want %h/1", if_pc, if_valid, ea); end
        checks++; if (instruction !== mem_word(ea)) begin errors++; $display("FAIL wait_instr got %h want %h", instruction, mem_word(ea)); end
        lp = ea;
        ea = ea + 64'd4;
      end else begin
        checks++; if (if_valid !== 1'b0 || instruction !== NOP) begin errors++; $display("FAIL wait_bubble got %h/%b want %h/0", instruction, if_valid, NOP); end
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL wait_req got %b want 1", bus.imem_req); end
      end
      checks++; if (bus.imem_addr !== ea) begin errors++; $display("FAIL wait_addr got %h want %h", bus.imem_addr, ea); end
    end
  endtask

  task automatic test_stall_skid;
    logic [63:0] a;
    a = ea;
    stall = 1; bus.imem_ack = 1;
    tick();
    bus.imem_ack = 0;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL skid_req got %b want 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== a + 64'd4) begin errors++; $display("FAIL skid_addr got %h want %h", bus.imem_addr, a + 64'd4); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (if_pc !== lp || if_valid !== 1'b1) begin errors++; $display("FAIL skid_hold got %h/%b want %h/1", if_pc, if_valid, lp); end
      if (k < 2) begin
        tick();
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL skid_req_hold got %b want 0", bus.imem_req); end
      end
    end
    stall = 0;
    tick();
    checks++; if (if_pc !== a || if_valid !== 1'b1 || instruction !== mem_word(a)) begin errors++; $display("FAIL skid_release got %h/%b/%h want %h/1/%h", if_pc, if_valid, instruction, a, mem_word(a)); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== a + 64'd4) begin errors++; $display("FAIL skid_resume got %b/%h want 1/%h", bus.imem_req, bus.imem_addr, a + 64'd4); end
    bus.imem_ack = 1;
    tick();
    checks++; if (if_pc !== a + 64'd4 || instruction !== mem_word(a + 64'd4)) begin errors++; $display("FAIL skid_next got %h want %h", if_pc, a + 64'd4); end
    lp = a + 64'd4;
    ea = a + 64'd8;
    checks++; if (bus.imem_addr !== ea) begin errors++; $display("FAIL skid_next_addr got %h want %h", bus.imem_addr, ea); end
  endtask

  task automatic test_branch;
    bus.imem_ack = 1; br_taken = 1; br_sel = 2'b10; br_reg_val = 64'h203;
    tick();
    checks++; if (if_pc !== ea || bus.imem_addr !== 64'h200) begin errors++; $display("FAIL br_reg got %h/%h want %h/200", if_pc, bus.imem_addr, ea); end
    br_taken = 0;
    tick();
    checks++; if (if_pc !== 64'h200 || bus.imem_addr !== 64'h204) begin errors++; $display("FAIL br_land got %h/%h want 200/204", if_pc, bus.imem_addr); end
    br_taken = 1; br_sel = 2'b00; BrAddr26 = 26'h3FFFFFE;
    tick();
    checks++; if (if_pc !== 64'h204 || if_valid !== 1'b1 || instruction !== mem_word(64'h204)) begin errors++; $display("FAIL b_delay_slot got %h/%b want 204/1", if_pc, if_valid); end
    checks++; if (bus.imem_addr !== 64'h1F8) begin errors++; $display("FAIL b_target got %h want 1f8", bus.imem_addr); end
    br_taken = 0;
    tick();
    checks++; if (if_pc !== 64'h1F8 || bus.imem_addr !== 64'h1FC) begin errors++; $display("FAIL b_land got %h/%h want 1f8/1fc", if_pc, bus.imem_addr); end
  endtask

  task automatic test_pending_redirect;
    bus.imem_ack = 1; br_taken = 1; br_sel = 2'b10; br_reg_val = 64'h300;
    tick();
    br_taken = 0;
    tick();
    checks++; if (if_pc !== 64'h300 || bus.imem_addr !== 64'h304) begin errors++; $display("FAIL pend_setup got %h/%h want 300/304", if_pc, bus.imem_addr); end
    br_taken = 1; br_sel = 2'b01; CondAddr19 = 19'd5; bus.imem_ack = 0;
    tick();
    br_taken = 0;
    checks++; if (if_valid !== 1'b0 || bus.imem_addr !== 64'h304) begin errors++; $display("FAIL pend_wait got %b/%h want 0/304", if_valid, bus.imem_addr); end
    tick();
    checks++; if (bus.imem_addr !== 64'h304 || bus.imem_req !== 1'b1) begin errors++; $display("FAIL pend_hold got %h/%b want 304/1", bus.imem_addr, bus.imem_req); end
    bus.imem_ack = 1;
    tick();
    checks++; if (if_pc !== 64'h304 || if_valid !== 1'b1) begin errors++; $display("FAIL pend_slot got %h/%b want 304/1", if_pc, if_valid); end
    checks++; if (bus.imem_addr !== 64'h314) begin errors++; $display("FAIL pend_target got %h want 314", bus.imem_addr); end
    br_taken = 1; br_sel = 2'b11; br_reg_val = 64'h123456789ABC1003;
    tick();
    br_taken = 0;
    checks++; if (if_pc !== 64'h314 || bus.imem_addr !== 64'h123456789ABC1000) begin errors++; $display("FAIL br_mask got %h/%h want 314/123456789abc1000", if_pc, bus.imem_addr); end
    tick();
    checks++; if (if_pc !== 64'h123456789ABC1000 || instruction !== mem_word(64'h123456789ABC1000)) begin errors++; $display("FAIL br_mask_land got %h want 123456789abc1000", if_pc); end
  endtask

  task automatic test_async_reset;
    bus.imem_ack = 0;
    tick();
    #2;
    reset = 0;
    #1;
    checks++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== RPC) begin errors++; $display("FAIL areset_bus got %b/%h want 0/%h", bus.imem_req, bus.imem_addr, RPC); end
    checks++; if (if_valid !== 1'b0 || instruction !== NOP || if_pc !== 64'h0) begin errors++; $display("FAIL areset_ifid got %b/%h/%h want 0/%h/0", if_valid, instruction, if_pc, NOP); end
    tick();
    reset = 1;
    tick();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RPC) begin errors++; $display("FAIL areset_refetch got %b/%h want 1/%h", bus.imem_req, bus.imem_addr, RPC); end
  endtask

  task automatic test_random;
    logic [63:0] exp_pc, tgt, pa, lt;
    logic        acc, waiting, st, lbv;
    longint      off;
    int          ndeliv;
    clear_inputs();
    reset = 0; tick(); reset = 1; tick();
    exp_pc = RPC; lbv = 0; lt = 0; ndeliv = 0;
    for (int c = 0; c < 800; c++) begin
      stall      = ($urandom % 4 == 0);
      br_taken   = ($urandom % 3 == 0);
      br_sel     = 2'($urandom);
      BrAddr26   = 26'($urandom);
      CondAddr19 = 19'($urandom);
      br_reg_val = {$urandom, $urandom};
      bus.imem_ack = bus.imem_req && ($urandom % 2 == 0);
      acc = br_taken && if_valid && !stall;
      if (br_sel == 2'b00) begin
        off = longint'(BrAddr26);
        if (BrAddr26 >= 26'h2000000) off = off - 64'sh4000000;
        tgt = if_pc + 64'(off * 4);
      end else if (br_sel == 2'b01) begin
        off = longint'(CondAddr19);
        if (CondAddr19 >= 19'h40000) off = off - 64'sh80000;
        tgt = if_pc + 64'(off * 4);
      end else begin
        tgt = br_reg_val - (br_reg_val % 64'd4);
      end
      waiting = bus.imem_req && !bus.imem_ack;
      pa = bus.imem_addr;
      st = stall;
      tick();
      checks++; if (bus.imem_addr % 64'd4 !== 64'd0) begin errors++; $display("FAIL rnd_align got %h", bus.imem_addr); end
      if (waiting) begin
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== pa) begin errors++; $display("FAIL rnd_stable got %b/%h want 1/%h", bus.imem_req, bus.imem_addr, pa); end
      end
      if (acc) begin lbv = 1; lt = tgt; end
      if (!st) begin
        if (if_valid) begin
          ndeliv++;
          checks++; if (if_pc !== exp_pc) begin errors++; $display("FAIL rnd_pc got %h want %h", if_pc, exp_pc); end
          checks++; if (instruction !== mem_word(exp_pc)) begin errors++; $display("FAIL rnd_instr got %h want %h", instruction, mem_word(exp_pc)); end
          exp_pc = lbv ? lt : exp_pc + 64'd4;
          lbv = 0;
        end else begin
          checks++; if (instruction !== NOP) begin errors++; $display("FAIL rnd_bubble got %h want %h", instruction, NOP); end
        end
      end
    end
    checks++; if (ndeliv < 100) begin errors++; $display("FAIL rnd_progress got %0d want >=100", ndeliv); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_states();
    test_stall_skid();
    test_branch();
    test_pending_redirect();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
